// File: rtl/mod_mul_seq.sv
// Bit-serial interleaved modular multiplier: result = (a * b) mod p.
// Scans the multiplier MSB first, one bit per cycle, keeping the accumulator reduced below p.
module mod_mul_seq #(
  parameter int WIDTH = 256
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] p,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [1:0]       o_dbg_state
);

  localparam int AW = WIDTH + 2;
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  // Handshake: start is sampled on a rising edge only while busy=0; done is a
  // one-cycle pulse with busy=0, and result stays valid until the next accept.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIN  = 2'd2
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_p;
  logic [AW-1:0]    r_acc;
  logic [CW-1:0]    r_cnt;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_result;

  logic             w_load;
  logic             w_step;
  logic             w_fin;
  logic [AW-1:0]    w_addend;
  logic [AW-1:0]    w_t;
  logic [AW-1:0]    w_p_ext;
  logic [AW-1:0]    w_2p_ext;
  logic [AW-1:0]    w_acc_nxt;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (start) w_next = S_CALC;
      S_CALC: if (r_cnt == '0) w_next = S_FIN;
      S_FIN:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Control outputs of the state machine
  always_comb begin
    w_load = 1'b0;
    w_step = 1'b0;
    w_fin  = 1'b0;
    case (r_state)
      S_IDLE: w_load = start;
      S_CALC: w_step = 1'b1;
      S_FIN:  w_fin  = 1'b1;
      default: ;
    endcase
  end

  // t = 2*acc + (bit ? a : 0) is below 3p, so at most two subtractions of p reduce it.
  always_comb begin
    w_addend  = r_b[r_cnt] ? {2'b00, r_a} : '0;
    w_t       = (r_acc << 1) + w_addend;
    w_p_ext   = {2'b00, r_p};
    w_2p_ext  = {1'b0, r_p, 1'b0};
    w_acc_nxt = w_t;
    if (w_t >= w_2p_ext) begin
      w_acc_nxt = w_t - w_2p_ext;
    end else if (w_t >= w_p_ext) begin
      w_acc_nxt = w_t - w_p_ext;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_a      <= '0;
      r_b      <= '0;
      r_p      <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_result <= '0;
    end else begin
      r_done <= w_fin;
      if (w_load) begin
        r_a    <= a;
        r_b    <= b;
        r_p    <= p;
        r_acc  <= '0;
        r_cnt  <= CW'(WIDTH - 1);
        r_busy <= 1'b1;
      end
      if (w_step) begin
        r_acc <= w_acc_nxt;
        if (r_cnt != '0) begin
          r_cnt <= r_cnt - 1'b1;
        end
      end
      if (w_fin) begin
        r_result <= r_acc[WIDTH-1:0];
        r_busy   <= 1'b0;
      end
    end
  end

  assign busy        = r_busy;
  assign done        = r_done;
  assign result      = r_result;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_mod_mul_seq.sv
// Directed and random checks of mod_mul_seq at WIDTH=8 and WIDTH=256 against
// plain modular arithmetic computed in the bench.
module tb_mod_mul_seq;

  logic clk;
  logic rst_n;

  logic       start8;
  logic [7:0] a8, b8, p8, res8;
  logic       busy8, done8;
  logic [1:0] dbg8;

  logic         start256;
  logic [255:0] a256, b256, p256, res256;
  logic         busy256, done256;
  logic [1:0]   dbg256;

  int n_total = 0;
  int n_bad   = 0;

  localparam logic [255:0] P_REF =
    256'h8542D69E_4C044F18_E8B92435_BF6FF7DE_45728391_5C45517D_722EDB8B_08F1DFC3;
  localparam logic [255:0] A_REF =
    256'h787968B4_FA32C3FD_2417842E_73BBFEFF_2F3C848B_6831D7E0_EC65228B_3937E498;

  mod_mul_seq #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .p(p8),
    .busy(busy8), .done(done8), .result(res8), .o_dbg_state(dbg8)
  );

  mod_mul_seq #(.WIDTH(256)) u_dut256 (
    .clk(clk), .rst_n(rst_n), .start(start256), .a(a256), .b(b256), .p(p256),
    .busy(busy256), .done(done256), .result(res256), .o_dbg_state(dbg256)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_total++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] mulmod(input logic [255:0] x, y, m);
    logic [511:0] prod;
    prod = {256'b0, x} * {256'b0, y};
    return 256'(prod % {256'b0, m});
  endfunction

  // Extended binary Euclid; keeps x1*a == u and x2*a == v (mod p).
  function automatic logic [255:0] inv_mod(input logic [255:0] a_i, p_i);
    logic [256:0] u, v, x1, x2, pp;
    u = {1'b0, a_i}; v = {1'b0, p_i}; x1 = 257'd1; x2 = 257'd0; pp = {1'b0, p_i};
    for (int it = 0; it < 4096 && u != 1 && v != 1 && u != 0 && v != 0; it++) begin
      if (!u[0]) begin
        u = u >> 1;
        x1 = x1[0] ? (x1 + pp) >> 1 : x1 >> 1;
      end else if (!v[0]) begin
        v = v >> 1;
        x2 = x2[0] ? (x2 + pp) >> 1 : x2 >> 1;
      end else if (u >= v) begin
        u = u - v;
        x1 = (x1 >= x2) ? x1 - x2 : x1 + pp - x2;
      end else begin
        v = v - u;
        x2 = (x2 >= x1) ? x2 - x1 : x2 + pp - x1;
      end
    end
    return (u == 1) ? x1[255:0] : x2[255:0];
  endfunction

  function automatic logic [255:0] rand256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [255:0] cur_res(input bit big);
    return big ? res256 : {248'b0, res8};
  endfunction

  // Caller has raised start with operands at the current negedge; returns at the
  // negedge of the done cycle so the next start can be issued immediately.
  task automatic run_op(input bit big, input logic [255:0] exp, input string tag, input int inj);
    int w;
    bit early_done, low_busy, res_moved;
    logic [255:0] prev;
    w = big ? 256 : 8;
    prev = cur_res(big);
    early_done = 0; low_busy = 0; res_moved = 0;
    @(negedge clk);
    if (big) start256 = 1'b0; else start8 = 1'b0;
    for (int k = 1; k <= w; k++) begin
      if (!(big ? busy256 : busy8)) low_busy = 1;
      if (big ? done256 : done8) early_done = 1;
      if (cur_res(big) !== prev) res_moved = 1;
      if (!big && k == inj) begin start8 = 1'b1; a8 = 8'd3; b8 = 8'd7; p8 = 8'd13; end
      if (!big && k == inj + 3) start8 = 1'b0;
      @(negedge clk);
    end
    if (!(big ? busy256 : busy8)) low_busy = 1;
    if (cur_res(big) !== prev) res_moved = 1;
    chk({tag, "_busy_during"}, 256'(low_busy), 256'd0);
    chk({tag, "_no_early_done"}, 256'(early_done), 256'd0);
    chk({tag, "_result_held"}, 256'(res_moved), 256'd0);
    @(negedge clk);
    chk({tag, "_done"}, 256'(big ? done256 : done8), 256'd1);
    chk({tag, "_busy_end"}, 256'(big ? busy256 : busy8), 256'd0);
    chk({tag, "_result"}, cur_res(big), exp);
  endtask

  task automatic idle_watch(input int n, input logic [255:0] exp_res, input string tag);
    bit saw;
    saw = 0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (done8 || busy8 || res8 !== exp_res[7:0]) saw = 1;
    end
    chk(tag, 256'(saw), 256'd0);
  endtask

  initial begin
    logic [255:0] inv_b;
    int pi, ai, bi;

    rst_n = 1'b0;
    start8 = 1'b0; a8 = '0; b8 = '0; p8 = '0;
    start256 = 1'b0; a256 = '0; b256 = '0; p256 = '0;
    repeat (3) @(negedge clk);
    chk("reset_busy8", 256'(busy8), 256'd0);
    chk("reset_done8", 256'(done8), 256'd0);
    chk("reset_res8", 256'(res8), 256'd0);
    chk("reset_busy256", 256'(busy256), 256'd0);
    chk("reset_done256", 256'(done256), 256'd0);
    chk("reset_res256", res256, 256'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Small field
    a8 = 8'd5; b8 = 8'd9; p8 = 8'd11; start8 = 1'b1;
    run_op(1'b0, 256'd1, "small", -1);
    idle_watch(4, 256'd1, "small_idle_after");

    // Busy protection: a second request arrives mid-operation
    a8 = 8'd5; b8 = 8'd9; p8 = 8'd11; start8 = 1'b1;
    run_op(1'b0, 256'd1, "busyprot", 5);
    idle_watch(12, 256'd1, "busyprot_not_executed");

    // Reset after four CALC cycles
    a8 = 8'd7; b8 = 8'd8; p8 = 8'd13; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("rst_mid_busy", 256'(busy8), 256'd0);
    chk("rst_mid_done", 256'(done8), 256'd0);
    chk("rst_mid_res", 256'(res8), 256'd0);
    idle_watch(12, 256'd0, "rst_mid_no_done");
    a8 = 8'd7; b8 = 8'd8; p8 = 8'd13; start8 = 1'b1;
    run_op(1'b0, 256'd4, "after_rst", -1);

    // Inversion check and edge values at full width
    inv_b = inv_mod(A_REF, P_REF);
    a256 = A_REF; b256 = inv_b; p256 = P_REF; start256 = 1'b1;
    run_op(1'b1, 256'd1, "inverse", -1);
    a256 = '0; b256 = P_REF - 1; start256 = 1'b1;
    run_op(1'b1, 256'd0, "a_zero", -1);
    a256 = P_REF - 1; b256 = P_REF - 1; start256 = 1'b1;
    run_op(1'b1, 256'd1, "pm1_sq", -1);
    a256 = 256'd1; b256 = P_REF - 1; start256 = 1'b1;
    run_op(1'b1, P_REF - 1, "one_pm1", -1);

    // Random back-to-back, WIDTH=8
    for (int i = 0; i < 1000; i++) begin
      pi = $urandom_range(255, 2);
      ai = $urandom_range(pi - 1, 0);
      bi = $urandom_range(pi - 1, 0);
      a8 = 8'(ai); b8 = 8'(bi); p8 = 8'(pi); start8 = 1'b1;
      run_op(1'b0, 256'((ai * bi) % pi), "rand8", -1);
    end

    // Random back-to-back, WIDTH=256
    for (int i = 0; i < 40; i++) begin
      p256 = rand256();
      p256[255] = 1'b1;
      a256 = rand256() % p256;
      b256 = rand256() % p256;
      start256 = 1'b1;
      run_op(1'b1, mulmod(a256, b256, p256), "rand256", -1);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
